systolic_drain: RTL and testbench
=================================

Name: systolic_drain

Overview:
- Result-drain sequencer for the systolic MAC array.
- After a matrix multiply completes, it steps the array's row-select through every row and captures each row of accumulated C values. It streams the rows out over a valid/ready interface.
- Optionally it zeroes each row's accumulators through the array's row write port once that row has been accepted.
- Sits between the array's Crow/Cout/WrEn/Cin ports and the result memory or DMA writer.

Parameters:
- BITS_C, 16, width of one accumulator value (matches array Cin/Cout)
- DIM, 8, array dimension; rows drained per operation and values per row

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to drain all DIM rows; sampled only in IDLE
- clear_en  input  1  sampled with start; 1 = zero each row after it is accepted
- busy  output  1  high in any state other than IDLE
- mac_hold  output  1  equals busy; top level gates array en low while high
- done  output  1  one-cycle pulse after the last row completes
- Crow  output  $clog2(DIM)  row select to the array
- WrEn  output  1  array row write enable
- Cin  output  signed [BITS_C-1:0] x DIM  array write data; constant all-zero
- Cout  input  signed [BITS_C-1:0] x DIM  array row read data; combinational from Crow
- out_valid  output  1  out_data holds a valid row
- out_ready  input  1  downstream accepts the row
- out_data  output  signed [BITS_C-1:0] x DIM  captured row
- out_idx  output  $clog2(DIM)  row number of out_data
- out_last  output  1  high with out_valid when out_idx==DIM-1

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; row counter 0; Crow=0.
  - WrEn, out_valid, out_last, done, busy, mac_hold = 0.
  - out_data = 0, out_idx = 0; clear flag = 0.
  - Reset mid-drain abandons the operation immediately: no partial clear write and no done pulse.
- IDLE: start=1 latches clear_en into the clear flag, sets row=0, and moves to CAPT. start=0 keeps IDLE.
- CAPT (1 cycle):
  - Crow=row.
  - At the clock edge: out_data<=Cout, out_idx<=row, out_last<=(row==DIM-1), out_valid<=1.
  - Next state SEND.
- SEND:
  - out_valid=1; out_data, out_idx and out_last are held stable while out_ready=0.
  - On out_valid&&out_ready: out_valid<=0.
  - Next state CLR if the clear flag is 1.
  - Otherwise: DONE if row==DIM-1, else row<=row+1 and CAPT.
- CLR (1 cycle):
  - WrEn=1, Crow=row, Cin all zero; the array zeroes that row at the edge.
  - Next state: DONE if row==DIM-1, else row<=row+1 and CAPT.
- DONE (1 cycle): done=1, busy still 1; next state IDLE with row=0. done is registered, not combinational from out_ready.
- Crow is driven from the row register at all times and is 0 in IDLE.
- WrEn is 1 only in CLR.
- Latency and throughput:
  - start at edge k gives out_valid high from cycle k+2.
  - With out_ready held 1: 2 cycles per row without clear, 3 with clear.
  - Total busy time without clear is 2*DIM+1 cycles; done is asserted in the final busy cycle.
- start while busy is ignored; it is not queued.
- clear_en changes during a drain have no effect; only the value latched at start is used.
- out_ready while out_valid=0 is ignored.
- Row counter has no wrap-around: DONE is entered exactly at row DIM-1.

Test Plan:
- Single drain, no clear, DIM=4, BITS_C=16:
  - Stimulus: array rows preset to row r, col c value = 16*r+c, out_ready=1, pulse start.
  - Response: out_valid first high 2 cycles after start; rows 0..3 appear in order with the exact values; out_last only on idx 3; done 9 cycles after start; WrEn never 1.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles on row 1.
  - Response: out_data stays {16,17,18,19} and out_idx stays 1; Crow does not advance; then resumes normally.
- Drain with clear:
  - Stimulus: clear_en=1 with start.
  - Response: exactly one WrEn pulse per row with Crow=0,1,2,3 in order and Cin=0; a second drain returns all-zero rows.
- Signed extremes:
  - Stimulus: row values -32768 and 32767.
  - Response: captured bit-exact, no sign corruption.
- start ignored while busy:
  - Stimulus: pulse start mid-drain.
  - Response: no restart and a single done pulse; an immediate start on the cycle after done begins a new drain.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 in the SEND state of row 2.
  - Response: all outputs drop to reset values asynchronously; no done; the next start drains from row 0.

Source files
------------

// File: rtl/systolic_drain.sv
// rtl/systolic_drain.sv - result-drain sequencer that streams systolic array rows out over valid/ready
module systolic_drain #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          clear_en,
    output logic                          busy,
    output logic                          mac_hold,
    output logic                          done,
    output logic [$clog2(DIM)-1:0]        Crow,
    output logic                          WrEn,
    output logic [DIM*BITS_C-1:0]         Cin,
    input  logic [DIM*BITS_C-1:0]         Cout,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIM*BITS_C-1:0]         out_data,
    output logic [$clog2(DIM)-1:0]        out_idx,
    output logic                          out_last
);

    localparam int RW = $clog2(DIM);
    localparam logic [RW-1:0] ROW_LAST = RW'(DIM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPT,
        S_SEND,
        S_CLR,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [RW-1:0]           r_row;
    logic                    r_clear;
    logic [DIM*BITS_C-1:0]   r_out_data;
    logic [RW-1:0]           r_out_idx;
    logic                    r_out_last;
    logic                    r_out_valid;

    logic                    w_last_row;
    logic                    w_accept;

    assign w_last_row = (r_row == ROW_LAST);
    assign w_accept   = r_out_valid && out_ready;

    // State register; reset abandons any drain in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection: capture, hand off, optionally clear, then advance or finish
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_CAPT;
            S_CAPT: w_next = S_SEND;
            S_SEND: begin
                if (w_accept) begin
                    if (r_clear)         w_next = S_CLR;
                    else if (w_last_row) w_next = S_DONE;
                    else                 w_next = S_CAPT;
                end
            end
            S_CLR:  w_next = w_last_row ? S_DONE : S_CAPT;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Row counter, clear flag and the output holding register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row       <= '0;
            r_clear     <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_clear <= clear_en;
                        r_row   <= '0;
                    end
                end
                S_CAPT: begin
                    r_out_data  <= Cout;
                    r_out_idx   <= r_row;
                    r_out_last  <= w_last_row;
                    r_out_valid <= 1'b1;
                end
                S_SEND: begin
                    if (w_accept) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (!r_clear && !w_last_row) r_row <= r_row + 1'b1;
                    end
                end
                S_CLR: begin
                    if (!w_last_row) r_row <= r_row + 1'b1;
                end
                S_DONE: begin
                    r_row <= '0;
                end
                default: begin
                    r_row <= '0;
                end
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mac_hold  = busy;
    assign done      = (r_state == S_DONE);
    assign WrEn      = (r_state == S_CLR);
    assign Crow      = r_row;
    assign Cin       = '0;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_systolic_drain.sv
// tb/tb_systolic_drain.sv - directed/randomized bench for systolic_drain with an array model and row-level reference
module tb_systolic_drain;

    localparam int BITS_C = 16;
    localparam int DIM    = 4;
    localparam int RW     = 2;
    localparam int DW     = DIM * BITS_C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          clear_en = 1'b0;
    logic          out_ready = 1'b1;
    logic          busy, mac_hold, done, WrEn, out_valid, out_last;
    logic [RW-1:0] Crow, out_idx;
    logic [DW-1:0] Cin, Cout, out_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    systolic_drain #(.BITS_C(BITS_C), .DIM(DIM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear_en  (clear_en),
        .busy      (busy),
        .mac_hold  (mac_hold),
        .done      (done),
        .Crow      (Crow),
        .WrEn      (WrEn),
        .Cin       (Cin),
        .Cout      (Cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Array model: combinational row read, row write on WrEn, bulk preload from the bench
    logic [BITS_C-1:0] arr       [DIM][DIM];
    logic [BITS_C-1:0] preset    [DIM][DIM];
    logic [BITS_C-1:0] model_mem [DIM][DIM];
    logic              load = 1'b0;

    always @(posedge clk) begin
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                if (load) arr[r][c] <= preset[r][c];
                else if (WrEn && Crow == RW'(r)) arr[r][c] <= Cin[c*BITS_C +: BITS_C];
    end

    always_comb begin
        Cout = '0;
        for (int c = 0; c < DIM; c++) Cout[c*BITS_C +: BITS_C] = arr[Crow][c];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack_row(input int r);
        logic [DW-1:0] p;
        for (int c = 0; c < DIM; c++) p[c*BITS_C +: BITS_C] = model_mem[r][c];
        return p;
    endfunction

    task automatic load_array();
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) model_mem[r][c] = preset[r][c];
    endtask

    // One full drain: stall row bp_row for bp_len cycles, optionally pulse start mid-drain
    task automatic drain(input bit clr, input int bp_row, input int bp_len, input bit poke);
        logic [DW-1:0] exp_rows [DIM];
        int            got_idx[$];
        logic [DW-1:0] got_data[$];
        logic          got_last[$];
        int            wr_rows[$];
        int            busy_cyc = 0;
        int            first_valid = -1;
        int            done_cnt = 0;
        int            done_at = -1;
        int            stalls = 0;
        for (int r = 0; r < DIM; r++) exp_rows[r] = pack_row(r);
        start = 1'b1; clear_en = clr; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear_en = ~clr;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cyc++;
            if (out_valid && first_valid < 0) first_valid = busy_cyc;
            if (out_valid && !out_ready) begin
                check("bp_data", out_data, exp_rows[bp_row]);
                check("bp_idx", out_idx, bp_row);
                check("bp_crow", Crow, bp_row);
            end
            if (out_valid && out_ready) begin
                got_idx.push_back(int'(out_idx));
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            if (WrEn) begin
                wr_rows.push_back(int'(Crow));
                check("cin_zero", Cin, 0);
            end
            if (done) begin
                done_cnt++;
                done_at = busy_cyc;
            end
            @(posedge clk); #1;
            start = poke && (busy_cyc == 3);
            if (out_valid && int'(out_idx) == bp_row && stalls < bp_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
        end
        start = 1'b0;
        check("busy_cycles", busy_cyc, DIM * (clr ? 3 : 2) + 1 + bp_len);
        check("first_valid", first_valid, 2);
        check("done_count", done_cnt, 1);
        check("done_last_busy", done_at, busy_cyc);
        check("row_count", got_idx.size(), DIM);
        for (int r = 0; r < got_idx.size() && r < DIM; r++) begin
            check("row_idx", got_idx[r], r);
            check("row_data", got_data[r], exp_rows[r]);
            check("row_last", got_last[r], (r == DIM - 1));
        end
        check("wren_count", wr_rows.size(), clr ? DIM : 0);
        for (int i = 0; i < wr_rows.size(); i++) check("wren_row", wr_rows[i], i);
        if (clr)
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++) model_mem[r][c] = '0;
    endtask

    task automatic random_preset();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) preset[r][c] = BITS_C'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_hold"}, mac_hold, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wren"}, WrEn, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_idx"}, out_idx, 0);
        check({tag, "_crow"}, Crow, 0);
    endtask

    initial begin
        int saw_row2;
        int done_seen;

        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) preset[r][c] = BITS_C'(16 * r + c);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        load_array();

        // Plain drain, then backpressure on row 1
        drain(1'b0, -1, 0, 1'b0);
        drain(1'b0, 1, 5, 1'b0);

        // Clear drain immediately followed by a drain that must read zeros
        drain(1'b1, -1, 0, 1'b0);
        drain(1'b0, -1, 0, 1'b0);

        // Signed extremes
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) preset[r][c] = ((r + c) % 2 == 1) ? 16'h7FFF : 16'h8000;
        load_array();
        drain(1'b0, 2, 3, 1'b0);

        // start while busy is ignored; start right after done begins a new drain
        random_preset();
        load_array();
        drain(1'b0, -1, 0, 1'b1);
        drain(1'b1, int'($urandom_range(0, DIM - 1)), int'($urandom_range(1, 4)), 1'b0);

        // Reset in SEND of row 2
        random_preset();
        load_array();
        saw_row2 = 0;
        start = 1'b1; clear_en = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(posedge clk); #1;
            if (out_valid && out_idx == 2'd2) begin
                out_ready = 1'b0;
                saw_row2 = 1;
                break;
            end
        end
        check("reached_row2", saw_row2, 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        done_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done || WrEn) done_seen++;
        end
        check("no_done_after_rst", done_seen, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        drain(1'b0, -1, 0, 1'b0);

        // Randomized drains
        for (int k = 0; k < 4; k++) begin
            random_preset();
            load_array();
            drain(1'($urandom_range(0, 1)), int'($urandom_range(0, DIM - 1)),
                  int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
